btb_pc_gen: RTL and testbench
=============================

// Module: btb_pc_gen
// PURPOSE
//  IF-stage next-PC generator with a direct-mapped branch target buffer (BTB).
//  Consumes taken_sel from the 2-bit branch predictor and the EXE-stage branch resolution.
//  Drives the fetch PC, carries the prediction down the pipe and raises flush on a mispredict.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset
//  BTB_IDX_W  4              index bits; BTB depth = 2**BTB_IDX_W
//  CNT_W      32             width of the performance counters
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-low
//  Istall         in   1   instruction-memory stall
//  Dstall         in   1   data-memory stall
//  taken_sel      in   1   predictor direction (1 = predict taken)
//  opcode_EXE     in   7   opcode of the instruction in EXE
//  pc_EXE         in   32  PC of the instruction in EXE
//  jump_sel       in   1   actual taken/redirect outcome of the instruction in EXE
//  target_EXE     in   32  actual target computed in EXE
//  pred_taken_EXE in   1   prediction carried from IF for the instruction in EXE
//  pred_tgt_EXE   in   32  predicted target carried from IF
//  pc_IF          out  32  current fetch PC
//  pred_taken_IF  out  1   prediction made for pc_IF (to pipeline regs)
//  pred_tgt_IF    out  32  predicted target for pc_IF (to pipeline regs)
//  flush          out  1   kill the IF/ID and ID/EXE contents
//  branch_cnt     out  CNT_W  resolved Btype/JAL/JALR count
//  mispred_cnt    out  CNT_W  mispredict count
// BEHAVIOUR
//  Reset state (rst low): pc_IF=RESET_PC, all BTB valid=0, counters=0; flush=0 and pred_taken_IF=0
//   follow from this state.
//  Stall: stall = Istall|Dstall. While stalled, pc_IF, the BTB and the counters hold, and flush=0.
//  Prediction (combinational on pc_IF):
//   - idx = pc_IF[BTB_IDX_W+1:2]; tag = pc_IF[31:BTB_IDX_W+2].
//   - hit = valid & (tag match).
//   - pred_taken_IF = hit & (is_jal | taken_sel).
//   - pred_tgt_IF = entry target when hit, else pc_IF+4.
//  Mispredict (combinational; mis is 0 unless opcode_EXE is Btype, JAL or JALR):
//   - mis = (jump_sel != pred_taken_EXE) | (jump_sel & target_EXE != pred_tgt_EXE).
//   - flush = mis & !stall.
//  Next PC (registered on each non-stalled cycle), in priority order:
//   1. mis: jump_sel ? target_EXE : pc_EXE+4
//   2. pred_taken_IF: pred_tgt_IF
//   3. otherwise: pc_IF+4
//   Latency: the redirect reaches pc_IF one cycle after flush.
//  BTB write (non-stalled cycle, opcode Btype/JAL, jump_sel=1):
//   - entry[idx(pc_EXE)] <= {valid=1, tag, target_EXE, is_jal=(opcode==JAL)}.
//   - The write overwrites any alias.
//   - Not-taken branches leave the BTB unchanged; direction is handled by the predictor.
//   - JALR is never written.
//  Same-cycle read/write of the same index: the read returns the OLD entry; no bypass.
//  PC arithmetic: modulo 2**32. pc_IF+4 wraps 32'hFFFF_FFFC -> 0. Targets are used as given.
//  Counters, on a non-stalled cycle:
//   - branch_cnt += 1 when opcode is Btype/JAL/JALR.
//   - mispred_cnt += 1 when mis.
//   - Both saturate at all-ones.
//  Reset mid-operation: asynchronous reset restores the reset state immediately.
//   Any pending redirect is discarded.
// STRUCTURE
//  Shared package: RISC-V opcode constants (Btype, JAL, JALR) and typedef btb_entry_t
//   {valid, tag, target[31:0], is_jal}.
//  One sub-module, btb_array: a flop array with combinational read and a synchronous write port.
//   Its valid bits are cleared by rst.
//  The rest stays in this module: PC register, next-PC mux, mispredict compare, counters.
// TESTING
//  1. Reset, no branches, no stalls -> pc_IF = 0,4,8,..., flush=0, pred_taken_IF=0.
//  2. Btype at 0x40, taken to 0x100, cold BTB, pred_taken_EXE=0:
//     -> flush=1, next pc_IF=0x100, BTB entry written, mispred_cnt=1.
//  3. Same branch refetched, taken_sel=1 -> pred_taken_IF=1 and pc_IF 0x40 -> 0x100.
//     When it resolves taken with a matching target -> flush=0.
//  4. Hit with taken_sel=0 but actually taken -> flush=1, redirect to target_EXE.
//     JAL hit with taken_sel=0 -> still predicted taken.
//  5. Mispredict in EXE while Dstall=1 for 3 cycles -> flush=0 and pc_IF held.
//     First non-stalled cycle -> flush=1, then redirect.
//  6. pc_IF=0xFFFF_FFFC, no hit -> next pc_IF=0.
//     rst pulsed low mid-redirect -> pc_IF=RESET_PC at once, BTB invalid, counters 0.

Source files
------------

// File: rtl/btb_pc_gen_pkg.sv
// Shared definitions for the IF-stage next-PC generator: control-transfer
// opcodes and the layout of one branch-target-buffer entry.
package btb_pc_gen_pkg;

    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Widest tag any index width can need (pc[31:2] with a zero-bit index).
    // Narrower configurations leave the upper tag bits tied to zero.
    localparam int TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic                 is_jal;
    } btb_entry_t;

    // True for every opcode that resolves as a branch or jump in EXE.
    function automatic logic is_cti(input logic [6:0] opcode);
        return (opcode == OP_BTYPE) || (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

endpackage

// File: rtl/btb_pc_gen_btb_array.sv
// Direct-mapped BTB storage: combinational read port, synchronous write port.
// Only the valid bits are reset; tag and target are don't-care while invalid.
module btb_pc_gen_btb_array
    import btb_pc_gen_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output btb_entry_t       rd_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t       wr_entry
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [DEPTH-1:0] valid_q;
    btb_entry_t       mem_q [DEPTH];

    // Valid bits: cleared by reset, set by each write.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Entry payload: written on demand, never reset.
    // NOTE: the payload array has no reset; a cleared valid bit masks whatever it holds.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_entry;
        end
    end

    // Read port: returns the stored entry, so a same-cycle write is not visible yet.
    // NOTE: the whole struct is assigned before a field is overridden, so no latch is inferred.
    always_comb begin
        rd_entry       = mem_q[rd_idx];
        rd_entry.valid = valid_q[rd_idx];
    end

endmodule

// File: rtl/btb_pc_gen.sv
// IF-stage next-PC generator: fetch PC register, BTB lookup/update,
// mispredict detection with flush, and saturating performance counters.
module btb_pc_gen
    import btb_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 4,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Istall,
    input  logic             Dstall,
    input  logic             taken_sel,
    input  logic [6:0]       opcode_EXE,
    input  logic [31:0]      pc_EXE,
    input  logic             jump_sel,
    input  logic [31:0]      target_EXE,
    input  logic             pred_taken_EXE,
    input  logic [31:0]      pred_tgt_EXE,
    output logic [31:0]      pc_IF,
    output logic             pred_taken_IF,
    output logic [31:0]      pred_tgt_IF,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int TAG_LSB = BTB_IDX_W + 2;

    logic                 stall;
    logic                 is_br;
    logic                 mis;
    logic                 hit;
    logic                 btb_we;
    logic [TAG_MAX_W-1:0] tag_if;
    logic [31:0]          pc_next;
    btb_entry_t           rd_entry;
    btb_entry_t           wr_entry;

    btb_pc_gen_btb_array #(
        .IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_IF[TAG_LSB-1:2]),
        .rd_entry (rd_entry),
        .wr_en    (btb_we),
        .wr_idx   (pc_EXE[TAG_LSB-1:2]),
        .wr_entry (wr_entry)
    );

    // Prediction, mispredict detection, BTB update request and next-PC selection.
    always_comb begin
        stall  = Istall | Dstall;
        is_br  = is_cti(opcode_EXE);
        tag_if = TAG_MAX_W'(pc_IF >> TAG_LSB);

        hit           = rd_entry.valid && (rd_entry.tag == tag_if);
        pred_taken_IF = hit && (rd_entry.is_jal || taken_sel);
        pred_tgt_IF   = hit ? rd_entry.target : pc_IF + 32'd4;

        mis   = is_br && ((jump_sel != pred_taken_EXE) ||
                          (jump_sel && (target_EXE != pred_tgt_EXE)));
        flush = mis && !stall;

        // JALR targets are register-dependent, so they are never cached.
        btb_we          = !stall && jump_sel &&
                          ((opcode_EXE == OP_BTYPE) || (opcode_EXE == OP_JAL));
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = TAG_MAX_W'(pc_EXE >> TAG_LSB);
        wr_entry.target = target_EXE;
        wr_entry.is_jal = (opcode_EXE == OP_JAL);

        if (mis) begin
            pc_next = jump_sel ? target_EXE : pc_EXE + 32'd4;
        end else if (pred_taken_IF) begin
            pc_next = pred_tgt_IF;
        end else begin
            pc_next = pc_IF + 32'd4;
        end
    end

    // Fetch PC register: advances on every non-stalled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_IF <= RESET_PC;
        end else if (!stall) begin
            pc_IF <= pc_next;
        end
    end

    // Saturating performance counters for resolved branches and mispredicts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (!stall) begin
            if (is_br && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mis && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_btb_pc_gen.sv
// Self-checking bench for btb_pc_gen: directed scenarios followed by random
// traffic, all compared against a behavioural model of the fetch unit.
module tb_btb_pc_gen;
    import btb_pc_gen_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          IDX_W    = 4;
    localparam int          DEPTH    = 16;
    localparam int          CNT_W    = 6;
    localparam int          CNT_MAX  = 63;
    localparam logic [6:0]  OP_ALU   = 7'b0110011;

    logic             clk = 1'b0;
    logic             rst;
    logic             Istall, Dstall, taken_sel, jump_sel, pred_taken_EXE;
    logic [6:0]       opcode_EXE;
    logic [31:0]      pc_EXE, target_EXE, pred_tgt_EXE;
    logic [31:0]      pc_IF, pred_tgt_IF;
    logic             pred_taken_IF, flush;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: fetch PC, BTB contents remembered by the full branch PC, counters.
    logic [31:0] m_pc;
    bit          m_valid [DEPTH];
    logic [31:0] m_bpc   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    bit          m_jal   [DEPTH];
    int          m_bcnt, m_mcnt;

    btb_pc_gen #(
        .RESET_PC  (RESET_PC),
        .BTB_IDX_W (IDX_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Istall         (Istall),
        .Dstall         (Dstall),
        .taken_sel      (taken_sel),
        .opcode_EXE     (opcode_EXE),
        .pc_EXE         (pc_EXE),
        .jump_sel       (jump_sel),
        .target_EXE     (target_EXE),
        .pred_taken_EXE (pred_taken_EXE),
        .pred_tgt_EXE   (pred_tgt_EXE),
        .pc_IF          (pc_IF),
        .pred_taken_IF  (pred_taken_IF),
        .pred_tgt_IF    (pred_tgt_IF),
        .flush          (flush),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_bcnt = 0;
        m_mcnt = 0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [31:0] pce, input logic js,
                         input logic [31:0] tgt, input logic pte, input logic [31:0] ptgt,
                         input logic ts, input logic is, input logic ds);
        opcode_EXE     = op;
        pc_EXE         = pce;
        jump_sel       = js;
        target_EXE     = tgt;
        pred_taken_EXE = pte;
        pred_tgt_EXE   = ptgt;
        taken_sel      = ts;
        Istall         = is;
        Dstall         = ds;
    endtask

    task automatic idle(input logic ts);
        drive(OP_ALU, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, ts, 1'b0, 1'b0);
    endtask

    // Called at a negedge with inputs already driven: checks outputs, then
    // advances the model across the next rising edge.
    task automatic step();
        int          idx;
        bit          hit, e_pt, is_br, mis, stalled, wr;
        logic [31:0] e_ptgt, n_pc;
        #1;
        idx     = int'((m_pc >> 2) % DEPTH);
        hit     = m_valid[idx] && ((m_bpc[idx] >> 6) == (m_pc >> 6));
        e_pt    = hit && (m_jal[idx] || taken_sel);
        e_ptgt  = hit ? m_tgt[idx] : m_pc + 32'd4;
        is_br   = (opcode_EXE == OP_BTYPE) || (opcode_EXE == OP_JAL) || (opcode_EXE == OP_JALR);
        mis     = is_br && ((jump_sel != pred_taken_EXE) ||
                            (jump_sel && target_EXE != pred_tgt_EXE));
        stalled = Istall || Dstall;

        check("pc_IF",         pc_IF,          m_pc);
        check("pred_taken_IF", 32'(pred_taken_IF), 32'(e_pt));
        check("pred_tgt_IF",   pred_tgt_IF,    e_ptgt);
        check("flush",         32'(flush),     32'(mis && !stalled));
        check("branch_cnt",    32'(branch_cnt),  32'(m_bcnt));
        check("mispred_cnt",   32'(mispred_cnt), 32'(m_mcnt));

        if (mis)       n_pc = jump_sel ? target_EXE : pc_EXE + 32'd4;
        else if (e_pt) n_pc = e_ptgt;
        else           n_pc = m_pc + 32'd4;
        wr = jump_sel && ((opcode_EXE == OP_BTYPE) || (opcode_EXE == OP_JAL));

        @(posedge clk);
        if (!stalled) begin
            m_pc = n_pc;
            if (wr) begin
                idx          = int'((pc_EXE >> 2) % DEPTH);
                m_valid[idx] = 1;
                m_bpc[idx]   = pc_EXE;
                m_tgt[idx]   = target_EXE;
                m_jal[idx]   = (opcode_EXE == OP_JAL);
            end
            if (is_br && m_bcnt < CNT_MAX) m_bcnt++;
            if (mis && m_mcnt < CNT_MAX)   m_mcnt++;
        end
        @(negedge clk);
    endtask

    // Force the fetch PC to a given address through a JALR mispredict.
    task automatic redirect(input logic [31:0] dest);
        drive(OP_JALR, 32'h0000_0300, 1'b1, dest, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        logic [31:0] pce, tgt;
        int          sel;

        model_reset();
        rst = 1'b0;
        idle(1'b0);
        #12;
        check("reset_pc",          pc_IF,            RESET_PC);
        check("reset_branch_cnt",  32'(branch_cnt),  32'h0);
        check("reset_mispred_cnt", 32'(mispred_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Sequential fetch with a cold BTB.
        for (int i = 0; i < 4; i++) begin idle(1'b0); step(); end

        // Cold taken Btype at 0x40 -> 0x100: mispredict and BTB fill.
        drive(OP_BTYPE, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0);
        step();
        idle(1'b0); step();

        // Refetch 0x40 with taken_sel=1: predicted to 0x100; resolves correctly.
        redirect(32'h40);
        idle(1'b1); step();
        drive(OP_BTYPE, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        step();

        // Hit with taken_sel=0, actually taken: mispredict.
        redirect(32'h40);
        idle(1'b0); step();
        drive(OP_BTYPE, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0);
        step();

        // JAL trained, then predicted taken even with taken_sel=0.
        drive(OP_JAL, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84, 1'b0, 1'b0, 1'b0);
        step();
        redirect(32'h80);
        idle(1'b0); step();

        // Mispredict held under Dstall for three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            drive(OP_BTYPE, 32'h60, 1'b0, 32'h180, 1'b1, 32'h180, 1'b0, 1'b0, 1'b1);
            step();
        end
        drive(OP_BTYPE, 32'h60, 1'b0, 32'h180, 1'b1, 32'h180, 1'b0, 1'b0, 1'b0);
        step();
        idle(1'b0); step();

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFC);
        idle(1'b0); step();
        idle(1'b0); step();

        // Asynchronous reset in the middle of a redirect.
        drive(OP_JALR, 32'h0000_0300, 1'b1, 32'h0000_0500, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        idle(1'b0);
        #1;
        check("midreset_pc",      pc_IF,            RESET_PC);
        check("midreset_bcnt",    32'(branch_cnt),  32'h0);
        check("midreset_mcnt",    32'(mispred_cnt), 32'h0);
        check("midreset_flush",   32'(flush),       32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        // Former hits at 0x40 and 0x80 must now miss.
        redirect(32'h40);
        idle(1'b1); step();
        redirect(32'h80);
        idle(1'b0); step();

        // Random traffic over a small address pool so BTB hits and aliases occur.
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 4));
            pce = 32'($urandom_range(0, 127)) << 2;
            tgt = 32'($urandom_range(0, 127)) << 2;
            drive((sel <= 1) ? OP_BTYPE : (sel == 2) ? OP_JAL : (sel == 3) ? OP_JALR : OP_ALU,
                  pce, 1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? tgt : 32'($urandom_range(0, 127)) << 2,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 9) == 0));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
